// File: rtl/chmu_pkg.sv
// Shared types and widths for the CHMU hot-page tracker front end and counter set.
package chmu_pkg;

   localparam int unsigned CHMU_ADDR_W = 21;
   localparam int unsigned CHMU_CNT_W  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      CLEAR = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [CHMU_ADDR_W-1:0] addr;
      logic [CHMU_CNT_W-1:0]  cnt;
   } hot_report_t;

endpackage

// File: rtl/chmu_hot_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO without a pop is dropped and flagged.
module chmu_hot_fifo #(
   parameter int unsigned DATA_W = 33,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata_c,
   output logic              empty_c,
   output logic              drop_c
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty_c = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty_c;
   // When full, the slot being popped this cycle is the one the push overwrites.
   assign do_push = push & (~full | do_pop);
   assign drop_c  = push & full & ~do_pop;
   assign rdata_c = empty_c ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/chmu_tracker_sched.sv
// CHMU front end: round-robin address arbiter, epoch sequencer with drain, hot-report FIFO.
module chmu_tracker_sched
   import chmu_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_SIZE  = CHMU_ADDR_W,
   parameter int unsigned CNT_SIZE   = CHMU_CNT_W,
   parameter int unsigned EPOCH_W    = 32,
   parameter int unsigned DRAIN_CYC  = 4,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         cfg_enable,
   input  logic [EPOCH_W-1:0]           cfg_epoch_len,
   input  logic                         sw_epoch_req,
   output logic [ADDR_SIZE-1:0]         cs_addr,
   output logic                         cs_addr_valid,
   output logic                         cs_epoch,
   input  logic [ADDR_SIZE-1:0]         cs_hot_addr,
   input  logic [CNT_SIZE-1:0]          cs_hot_cnt,
   input  logic                         cs_hot_valid,
   output logic [ADDR_SIZE-1:0]         hot_addr,
   output logic [CNT_SIZE-1:0]          hot_cnt,
   output logic                         hot_valid,
   input  logic                         hot_ready,
   output logic [15:0]                  epoch_count,
   output logic [15:0]                  drop_count,
   output logic                         busy
);

   localparam int unsigned PTR_W   = $clog2(NUM_REQ);
   localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam int unsigned REP_W   = ADDR_SIZE + CNT_SIZE;

   sched_state_e         state_q, state_d;
   logic [EPOCH_W-1:0]   timer_q;
   logic [DRAIN_W-1:0]   drain_q;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     cand;
   logic                 grant_found;
   logic                 grant_en;
   logic [ADDR_SIZE-1:0] req_addr_a [NUM_REQ];
   logic [REP_W-1:0]     fifo_rdata;
   logic                 fifo_empty;
   logic                 fifo_drop;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
      assign req_addr_a[g] = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
   end

   // First valid stream at or after the round-robin pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = rr_ptr_q + PTR_W'(i);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         IDLE: if (cfg_enable) state_d = RUN;
         RUN: begin
            grant_en = grant_found;
            if ((cfg_epoch_len != '0 && timer_q == cfg_epoch_len - EPOCH_W'(1)) ||
                sw_epoch_req || !cfg_enable)
               state_d = DRAIN;
         end
         DRAIN: if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = CLEAR;
         CLEAR: state_d = cfg_enable ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
      req_ready = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q       <= '0;
         drain_q       <= '0;
         rr_ptr_q      <= '0;
         cs_addr       <= '0;
         cs_addr_valid <= 1'b0;
         cs_epoch      <= 1'b0;
         busy          <= 1'b0;
         epoch_count   <= '0;
         drop_count    <= '0;
      end else begin
         if (state_q == CLEAR)    timer_q <= '0;
         else if (state_q == RUN) timer_q <= timer_q + EPOCH_W'(1);
         drain_q <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
         if (grant_en) begin
            rr_ptr_q <= grant_idx + PTR_W'(1);
            cs_addr  <= req_addr_a[grant_idx];
         end
         cs_addr_valid <= grant_en;
         cs_epoch      <= (state_d == CLEAR);
         busy          <= (state_d != IDLE);
         if (state_q == CLEAR) epoch_count <= epoch_count + 16'd1;
         if (fifo_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

   chmu_hot_fifo #(
      .DATA_W (REP_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_hot_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cs_hot_valid),
      .wdata   ({cs_hot_addr, cs_hot_cnt}),
      .pop     (hot_ready),
      .rdata_c (fifo_rdata),
      .empty_c (fifo_empty),
      .drop_c  (fifo_drop)
   );

   assign hot_valid = ~fifo_empty;
   assign hot_addr  = fifo_rdata[CNT_SIZE +: ADDR_SIZE];
   assign hot_cnt   = fifo_rdata[CNT_SIZE-1:0];

endmodule

// File: doc/chmu_tracker_sched.md
Name: chmu_tracker_sched

Overview:
- Front-end controller for the CHMU hot-page counter set.
- Round-robin arbitrates NUM_REQ page-address request streams (one per CXL channel) into the counter set's single-address-per-cycle input.
- Sequences epoch boundaries: periodic timer or software request, with pipeline drain before the clear pulse.
- Buffers the counter set's hot-page reports in a FIFO for host/DMA readout.

Parameters:
NUM_REQ, 4, number of requester streams (power of 2, 2..8)
ADDR_SIZE, 21, page-address width (4KB DPA unit)
CNT_SIZE, 12, hot-count width
EPOCH_W, 32, epoch timer width
DRAIN_CYC, 4, idle cycles between last grant and epoch pulse (covers the 3-stage counter pipeline plus report register)
FIFO_DEPTH, 16, hot-report FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  NUM_REQ  per-stream address valid
req_addr  in  NUM_REQ*ADDR_SIZE  per-stream page address; stream i occupies bits [i*ADDR_SIZE +: ADDR_SIZE]
req_ready  out  NUM_REQ  per-stream grant; a transfer occurs when valid&ready
cfg_enable  in  1  tracking enable
cfg_epoch_len  in  EPOCH_W  cycles per epoch; 0 disables the timer
sw_epoch_req  in  1  single-cycle software epoch request
cs_addr  out  ADDR_SIZE  address to counter set
cs_addr_valid  out  1  address valid to counter set
cs_epoch  out  1  clear pulse to counter set
cs_hot_addr  in  ADDR_SIZE  hot report address from counter set
cs_hot_cnt  in  CNT_SIZE  hot report count
cs_hot_valid  in  1  hot report valid
hot_addr  out  ADDR_SIZE  FIFO head address
hot_cnt  out  CNT_SIZE  FIFO head count
hot_valid  out  1  FIFO non-empty
hot_ready  in  1  consumer pop
epoch_count  out  16  completed epochs, wraps
drop_count  out  16  hot reports lost to FIFO full, saturates at 0xFFFF
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-low, on rst_n; clock is clk. Reset values: all outputs 0, state IDLE, RR pointer 0, timer 0, FIFO empty.
- FSM states: IDLE, RUN, DRAIN, CLEAR.
- IDLE: req_ready = 0. Goes to RUN when cfg_enable = 1.
- RUN:
  - Grant at most one stream per cycle, combinationally, to the first valid stream at or after the RR pointer (wrapping). On grant to stream k, the pointer becomes k+1 mod NUM_REQ.
  - cs_addr / cs_addr_valid are registered: the granted address appears one cycle after the handshake. cs_addr_valid = 0 on cycles with no grant.
  - Timer increments every RUN cycle.
  - Go to DRAIN if any of:
    - cfg_epoch_len != 0 and timer == cfg_epoch_len-1
    - sw_epoch_req = 1
    - cfg_enable = 0
  - The cycle that transitions to DRAIN still grants.
- DRAIN:
  - req_ready = 0; cs_addr_valid goes low the next cycle.
  - Counts DRAIN_CYC cycles, then goes to CLEAR.
  - Hot reports continue to be captured.
- CLEAR:
  - cs_epoch = 1 for exactly this one cycle.
  - epoch_count += 1; timer cleared.
  - Next state is RUN if cfg_enable = 1, else IDLE.
- sw_epoch_req arriving in DRAIN or CLEAR is merged into the in-progress epoch (no second epoch). In IDLE it is ignored.
- Changing cfg_epoch_len mid-epoch takes effect on the next compare. A new value ≤ the current timer delays the epoch until the timer wraps; this is acceptable and documented.
- Hot FIFO:
  - Push on cs_hot_valid; pop on hot_valid & hot_ready. Show-ahead: the head is visible combinationally from registered storage.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the report and increments drop_count (saturating).
  - The FIFO is not flushed by an epoch. Only reset empties it.
- Reset mid-epoch or mid-drain returns to IDLE immediately; in-flight requests are abandoned and the FIFO is emptied.

Decomposition:
- Shared package chmu_pkg: sched_state_e enum (IDLE, RUN, DRAIN, CLEAR), hot_report_t packed struct {addr, cnt}, address/count width constants shared with the counter set.
- One sub-module: chmu_hot_fifo, a parameterized show-ahead sync FIFO with full/empty and drop strobe.
- Arbiter and FSM stay in the top module.

Test Plan:
- All 4 streams valid continuously, addresses 0x10 to 0x13 → grants cycle 0,1,2,3,0…; cs_addr shows 0x10,0x11,0x12,0x13 with 1-cycle latency; no stream starved.
- cfg_epoch_len = 100, stream 0 always valid → grants stop after timer 99; cs_epoch pulses exactly DRAIN_CYC+1 cycles later; epoch_count = 1; grants resume the following cycle.
- sw_epoch_req pulsed twice, 2 cycles apart (second during DRAIN) → exactly one cs_epoch pulse; epoch_count increments by 1.
- 20 cs_hot_valid reports with hot_ready = 0 → 16 stored, drop_count = 4. Drain 16 in order with hot_ready = 1 → addresses match the first 16 pushed.
- Deassert cfg_enable mid-RUN → DRAIN, one cs_epoch pulse, then IDLE with busy = 0 and req_ready = 0.
- rst_n low in the middle of DRAIN → next cycle all outputs 0, state IDLE, hot_valid = 0.
